// File: rtl/mdu_unit_pkg.sv
// Shared encodings and types for the multiply/divide unit.
package mdu_unit_pkg;

    // MDUOp encodings, shared with the decoder alongside the ALUOp codes
    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MFHI  = 4'd7;
    localparam logic [3:0] MDU_MFLO  = 4'd8;

    // Busy-counter width; comfortably holds any realistic cycle count
    localparam int CNT_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    // True for the operations that occupy the unit for several cycles
    function automatic logic is_long_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit multiply/divide result, split into HI and LO.
// Divide by zero returns the current HI/LO so the commit leaves them unchanged.
module mdu_calc
    import mdu_unit_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    input  logic [31:0] cur_hi,
    input  logic [31:0] cur_lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] sa;
    logic signed [31:0] sb_safe;
    logic        [31:0] ub_safe;
    logic signed [31:0] q_s;
    logic signed [31:0] r_s;
    logic        [31:0] q_u;
    logic        [31:0] r_u;
    logic               div_zero;
    logic               div_ovf;

    assign sa       = $signed(a);
    assign div_zero = (b == 32'd0);
    // Most-negative / -1 overflows; the quotient wraps to itself, remainder 0
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    // Substitute a harmless divisor on the special cases so the divider never sees them
    assign sb_safe  = (div_zero || div_ovf) ? 32'sd1 : $signed(b);
    assign ub_safe  = div_zero ? 32'd1 : b;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};
    assign q_s    = sa / sb_safe;
    assign r_s    = sa % sb_safe;
    assign q_u    = a / ub_safe;
    assign r_u    = a % ub_safe;

    // Select the result for the requested operation
    always_comb begin
        res_hi = cur_hi;
        res_lo = cur_lo;
        case (op)
            MDU_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MDU_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MDU_DIV: begin
                if (div_ovf) begin
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else if (!div_zero) begin
                    res_hi = r_s;
                    res_lo = q_s;
                end
            end
            MDU_DIVU: begin
                if (!div_zero) begin
                    res_hi = r_u;
                    res_lo = q_u;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: holds HI/LO, models fixed mult/div latency
// with a down-counter, and drives the mfhi/mflo read value.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    mdu_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [31:0]      tmp_hi_reg, tmp_hi_next;
    logic [31:0]      tmp_lo_reg, tmp_lo_next;
    logic [31:0]      hi_reg, hi_next;
    logic [31:0]      lo_reg, lo_next;
    logic [31:0]      calc_hi;
    logic [31:0]      calc_lo;

    mdu_calc u_calc (
        .a      (A),
        .b      (B),
        .op     (MDUOp),
        .cur_hi (hi_reg),
        .cur_lo (lo_reg),
        .res_hi (calc_hi),
        .res_lo (calc_lo)
    );

    // State, counter, pending result and architectural HI/LO registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            tmp_hi_reg <= '0;
            tmp_lo_reg <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            tmp_hi_reg <= tmp_hi_next;
            tmp_lo_reg <= tmp_lo_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
        end
    end

    // Next-state logic: accept work only in IDLE, commit when the counter expires
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        tmp_hi_next = tmp_hi_reg;
        tmp_lo_next = tmp_lo_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (is_long_op(MDUOp)) begin
                        tmp_hi_next = calc_hi;
                        tmp_lo_next = calc_lo;
                        state_next  = ST_RUN;
                        if ((MDUOp == MDU_MULT) || (MDUOp == MDU_MULTU))
                            cnt_next = CNT_W'(MULT_CYCLES);
                        else
                            cnt_next = CNT_W'(DIV_CYCLES);
                    end else if (MDUOp == MDU_MTHI) begin
                        hi_next = A;
                    end else if (MDUOp == MDU_MTLO) begin
                        lo_next = A;
                    end
                end
            end
            ST_RUN: begin
                // Starts arriving here are dropped; the hazard unit should prevent them
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == CNT_W'(1)) begin
                    hi_next    = tmp_hi_reg;
                    lo_next    = tmp_lo_reg;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state_reg == ST_RUN);
    assign HI   = hi_reg;
    assign LO   = lo_reg;

    // Read port for mfhi/mflo into the E-stage result mux
    always_comb begin
        MDUOut = 32'd0;
        if (MDUOp == MDU_MFHI)
            MDUOut = hi_reg;
        else if (MDUOp == MDU_MFLO)
            MDUOut = lo_reg;
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed testbench for mdu_unit: latency, arithmetic, ignored starts, async reset.
module tb_mdu_unit;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    logic        clk;
    logic        reset_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDUOp;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUOut;

    int errors = 0;
    int checks = 0;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .A       (A),
        .B       (B),
        .MDUOp   (MDUOp),
        .start   (start),
        .busy    (busy),
        .HI      (HI),
        .LO      (LO),
        .MDUOut  (MDUOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one op for a single rising edge; returns on the following falling edge
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        MDUOp = op;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        MDUOp = OP_NONE;
        $display("issue op=%0d A=%08h B=%08h busy=%0b", op, a, b, busy);
    endtask

    // Count falling edges with busy high, bounded
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_hilo(input string name, input int n, input int exp_n,
                              input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        checks++;
        if (n != exp_n) begin
            errors++;
            $display("FAIL %s busy_cycles got=%0d exp=%0d", name, n, exp_n);
        end
        checks++;
        if (HI !== exp_hi || LO !== exp_lo) begin
            errors++;
            $display("FAIL %s hilo got=%08h/%08h exp=%08h/%08h", name, HI, LO, exp_hi, exp_lo);
        end
        $display("%s busy=%0d HI=%08h LO=%08h", name, n, HI, LO);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        MDUOp   = OP_NONE;
        A       = '0;
        B       = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || MDUOut !== 32'd0) begin
            errors++;
            $display("FAIL reset got busy=%0b HI=%08h LO=%08h out=%08h exp 0/0/0/0",
                     busy, HI, LO, MDUOut);
        end
        // start low with a multiply selected must not begin anything
        MDUOp = OP_MULT; A = 32'd3; B = 32'd3;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL nostart got busy=%0b LO=%08h exp 0/0", busy, LO);
        end
        MDUOp = OP_NONE;
        $display("reset busy=%0b HI=%08h LO=%08h", busy, HI, LO);
    endtask

    task automatic test_mult();
        int n;
        issue(OP_MULT, 32'hFFFF_FFFF, 32'd2);
        count_busy(n);
        check_hilo("mult", n, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        count_busy(n);
        check_hilo("multu", n, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    endtask

    task automatic test_div();
        int n;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        count_busy(n);
        check_hilo("div", n, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(OP_DIVU, 32'd7, 32'd2);
        count_busy(n);
        check_hilo("divu", n, 10, 32'd1, 32'd3);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(n);
        check_hilo("div_ovf", n, 10, 32'd0, 32'h8000_0000);
    endtask

    task automatic test_mthi_divzero();
        int n;
        issue(OP_MTHI, 32'h1234_5678, 32'd0);
        checks++;
        if (HI !== 32'h1234_5678 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi got HI=%08h busy=%0b exp 12345678/0", HI, busy);
        end
        issue(OP_MTLO, 32'h9ABC_DEF0, 32'd0);
        checks++;
        if (LO !== 32'h9ABC_DEF0) begin
            errors++;
            $display("FAIL mtlo got LO=%08h exp 9abcdef0", LO);
        end
        issue(OP_DIV, 32'd55, 32'd0);
        count_busy(n);
        check_hilo("divzero", n, 10, 32'h1234_5678, 32'h9ABC_DEF0);
        MDUOp = OP_MFHI;
        #1;
        checks++;
        if (MDUOut !== 32'h1234_5678) begin
            errors++;
            $display("FAIL mfhi got=%08h exp=12345678", MDUOut);
        end
        MDUOp = OP_MFLO;
        #1;
        checks++;
        if (MDUOut !== 32'h9ABC_DEF0) begin
            errors++;
            $display("FAIL mflo got=%08h exp=9abcdef0", MDUOut);
        end
        MDUOp = OP_NONE;
        #1;
        checks++;
        if (MDUOut !== 32'd0) begin
            errors++;
            $display("FAIL mdunone got=%08h exp=0", MDUOut);
        end
        $display("mfhi/mflo reads done");
    endtask

    task automatic test_back_to_back();
        int n;
        issue(OP_MULT, 32'd3, 32'd4);
        // busy cycle 1 now; advance to cycle 2 and try a second multiply
        @(negedge clk);
        start = 1'b1; MDUOp = OP_MULT; A = 32'd5; B = 32'd5;
        @(negedge clk);
        start = 1'b0;
        // read while busy returns the old LO
        MDUOp = OP_MFLO;
        #1;
        checks++;
        if (MDUOut !== 32'h9ABC_DEF0) begin
            errors++;
            $display("FAIL mflo_busy got=%08h exp=9abcdef0", MDUOut);
        end
        MDUOp = OP_NONE;
        count_busy(n);
        check_hilo("ignored_start", n + 2, 5, 32'd0, 32'd12);
        // first idle cycle: new multiply accepted immediately
        start = 1'b1; MDUOp = OP_MULT; A = 32'd7; B = 32'd8;
        @(negedge clk);
        start = 1'b0; MDUOp = OP_NONE;
        count_busy(n);
        check_hilo("back_to_back", n, 5, 32'd0, 32'd56);
    endtask

    task automatic test_async_reset();
        int n;
        issue(OP_MTHI, 32'h0000_DEAD, 32'd0);
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL async_reset got busy=%0b HI=%08h LO=%08h exp 0/0/0", busy, HI, LO);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL post_reset got busy=%0b HI=%08h LO=%08h exp 0/0/0", busy, HI, LO);
        end
        $display("async_reset busy=%0b HI=%08h LO=%08h", busy, HI, LO);
        issue(OP_MULT, 32'd6, 32'd7);
        count_busy(n);
        check_hilo("mult_after_reset", n, 5, 32'd0, 32'd42);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_divzero();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
Multiply/divide unit in the E stage, operating alongside the ALU on the same forwarded A/B operands.
- Executes MIPS mult, multu, div, divu, mthi and mtlo.
- Holds the architectural HI and LO registers.
- Drives the mfhi/mflo read value into the E-stage result mux.
- Raises busy so the hazard unit stalls any later MDU instruction in D.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu.
- DIV_CYCLES, 10, busy duration in cycles for div/divu.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- A  input  32  rs operand, already forwarded
- B  input  32  rt operand, already forwarded
- MDUOp  input  4  operation select: NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO
- start  input  1  instruction in E is valid and not flushed; qualifies MDUOp
- busy  output  1  operation in progress
- HI  output  32  architectural HI
- LO  output  32  architectural LO
- MDUOut  output  32  HI when MDUOp=MFHI, LO when MDUOp=MFLO, else 0 (combinational)

Behaviour:
- Reset (async, reset_n=0): HI=0, LO=0, busy=0, counter=0, temp regs=0. A reset mid-operation aborts it; HI/LO stay 0.
- States: IDLE, RUN. busy = (state==RUN).
- IDLE, start=1, MDUOp in {MULT,MULTU,DIV,DIVU}:
  - At this edge, latch the 64-bit result into tmp_hi/tmp_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES, go to RUN.
  - busy is high from the cycle after the start edge.
- RUN:
  - Counter decrements every edge.
  - At the edge where counter goes 1 -> 0: HI<=tmp_hi, LO<=tmp_lo, return to IDLE.
  - busy is high for exactly N cycles; HI/LO show the new values in the first cycle busy is low.
- MTHI/MTLO with start=1 in IDLE: HI<=A or LO<=A at that edge, zero latency.
- Any start while busy=1 is ignored: no state or HI/LO change. The hazard unit guarantees this never happens in a correct pipeline; the bench checks it anyway.
- MFHI/MFLO are pure reads. They must not occur while busy; if they do, MDUOut returns the old HI/LO.
- start=0 means no MDU operation starts, whatever MDUOp holds.
- mult: signed 32x32 -> 64; HI = upper 32 bits, LO = lower 32 bits.
- multu: unsigned 32x32 -> 64, same HI/LO split.
- div: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero (B=0): the full DIV_CYCLES busy period still runs; HI and LO keep their previous values (tmp loaded from current HI/LO).
- Back-to-back: a new start in the first cycle busy is low is accepted normally.
- No interaction with the ALU; the E-stage mux picks MDUOut for mfhi/mflo.

Decomposition:
- Shared settings/defines hold the MDUOp encodings `MDUNone=0, `MDUMult=1, `MDUMultu=2, `MDUDiv=3, `MDUDivu=4, `MDUMthi=5, `MDUMtlo=6, `MDUMfhi=7, `MDUMflo=8, alongside the ALUOp defines.
- Optional sub-module mdu_calc: combinational 64-bit result from A, B, op and the current HI/LO, covering the signed/unsigned and div-by-zero rules. The sequencing (FSM, counter, HI/LO) stays in mdu_unit.

Test Plan:
1. mult, A=0xFFFFFFFF, B=2 -> busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
2. multu, A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
3. div, A=-7 (0xFFFFFFF9), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - Then divu, A=7, B=2 -> LO=3, HI=1.
4. mthi A=0x12345678, mtlo A=0x9ABCDEF0, then div with B=0 -> busy 10 cycles; HI/LO stay 0x12345678/0x9ABCDEF0.
   - MFHI then reads MDUOut=0x12345678.
5. mult 3*4 started; second mult 5*5 with start=1 at busy cycle 2 -> ignored. Final HI=0, LO=12, busy low after 5 cycles.
   - A new mult issued in the first idle cycle is accepted.
6. reset_n pulsed low asynchronously during div busy cycle 4 -> busy, HI and LO drop to 0 immediately, no later update.
   - A mult 6*7 after release gives LO=42.
